// File: rtl/forward_propagation_hidden_node.sv
// forward_propagation_hidden_node
// One hidden-layer neuron of the forward pass: y = ReLU(sum_k x[k]*w[k] + b) in FP32.
// Input activations are buffered locally, weights and bias are read one at a time from the
// weight RAM, and every multiply/add is issued to a shared external FP unit, one at a time.

`timescale 1ns/1ps

module forward_propagation_hidden_node #(
    parameter int DATA_WIDTH          = 32,
    parameter int ADDRESS_WIDTH       = 11,
    parameter int ADDRESS_NODE        = 0,
    parameter int NUMBER_OF_BACK_NODE = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_ready,
    output logic [ADDRESS_WIDTH-1:0] o_weight_addr,
    output logic                     o_weight_en,
    input  logic [DATA_WIDTH-1:0]    i_weight,
    output logic                     o_fp_op,
    output logic [DATA_WIDTH-1:0]    o_fp_a,
    output logic [DATA_WIDTH-1:0]    o_fp_b,
    output logic                     o_fp_valid,
    input  logic [DATA_WIDTH-1:0]    i_fp_result,
    input  logic                     i_fp_valid,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_valid
);

    localparam int N     = NUMBER_OF_BACK_NODE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(N - 1);
    // Each neuron owns N weights followed by its bias in the shared weight RAM.
    localparam logic [ADDRESS_WIDTH-1:0] BASE_ADDR = ADDRESS_WIDTH'(ADDRESS_NODE * (N + 1));
    localparam logic [ADDRESS_WIDTH-1:0] BIAS_ADDR = ADDRESS_WIDTH'(ADDRESS_NODE * (N + 1) + N);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WLAT,
        MUL,
        WAIT_MUL,
        ADD,
        WAIT_ADD,
        NEXT,
        BIAS_FETCH,
        BIAS_LAT,
        BIAS_ADD,
        WAIT_BIAS,
        ACT
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic [DATA_WIDTH-1:0]   x_buf [N];
    logic [IDX_W-1:0]        cnt;
    logic [IDX_W-1:0]        k;
    logic [DATA_WIDTH-1:0]   weight;
    logic [DATA_WIDTH-1:0]   product;
    logic [DATA_WIDTH-1:0]   acc;

    logic                    last_beat;

    assign last_beat = i_valid && (cnt == IDX_LAST);

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and all handshake/request outputs, decoded from the current state.
    always_comb begin
        next_state    = state;
        o_ready       = 1'b0;
        o_weight_en   = 1'b0;
        o_weight_addr = '0;
        o_fp_valid    = 1'b0;
        o_fp_op       = 1'b0;
        o_fp_a        = '0;
        o_fp_b        = '0;

        unique case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (last_beat) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                o_weight_en   = 1'b1;
                o_weight_addr = BASE_ADDR + ADDRESS_WIDTH'(k);
                next_state    = WLAT;
            end
            WLAT: begin
                next_state = MUL;
            end
            MUL: begin
                o_fp_valid = 1'b1;
                o_fp_op    = 1'b0;
                o_fp_a     = x_buf[k];
                o_fp_b     = weight;
                next_state = WAIT_MUL;
            end
            WAIT_MUL: begin
                if (i_fp_valid) begin
                    next_state = (k == '0) ? NEXT : ADD;
                end
            end
            ADD: begin
                o_fp_valid = 1'b1;
                o_fp_op    = 1'b1;
                o_fp_a     = acc;
                o_fp_b     = product;
                next_state = WAIT_ADD;
            end
            WAIT_ADD: begin
                if (i_fp_valid) begin
                    next_state = NEXT;
                end
            end
            NEXT: begin
                next_state = (k == IDX_LAST) ? BIAS_FETCH : FETCH;
            end
            BIAS_FETCH: begin
                o_weight_en   = 1'b1;
                o_weight_addr = BIAS_ADDR;
                next_state    = BIAS_LAT;
            end
            BIAS_LAT: begin
                next_state = BIAS_ADD;
            end
            BIAS_ADD: begin
                o_fp_valid = 1'b1;
                o_fp_op    = 1'b1;
                o_fp_a     = acc;
                o_fp_b     = weight;
                next_state = WAIT_BIAS;
            end
            WAIT_BIAS: begin
                if (i_fp_valid) begin
                    next_state = ACT;
                end
            end
            ACT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Input activation buffer; contents are only meaningful once all N beats have arrived.
    always_ff @(posedge clk) begin
        if (state == IDLE && i_valid) begin
            x_buf[cnt] <= i_data;
        end
    end

    // Counters, operand holding registers, accumulator and the registered ReLU output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            k       <= '0;
            weight  <= '0;
            product <= '0;
            acc     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (cnt == IDX_LAST) begin
                            cnt <= '0;
                            k   <= '0;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                WLAT, BIAS_LAT: begin
                    weight <= i_weight;
                end
                WAIT_MUL: begin
                    if (i_fp_valid) begin
                        product <= i_fp_result;
                        if (k == '0) begin
                            acc <= i_fp_result;
                        end
                    end
                end
                WAIT_ADD, WAIT_BIAS: begin
                    if (i_fp_valid) begin
                        acc <= i_fp_result;
                    end
                end
                NEXT: begin
                    if (k != IDX_LAST) begin
                        k <= k + IDX_W'(1);
                    end
                end
                ACT: begin
                    o_data  <= acc[DATA_WIDTH-1] ? '0 : acc;
                    o_valid <= 1'b1;
                    k       <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_forward_propagation_hidden_node.sv
// tb_forward_propagation_hidden_node
// Directed bench: two neuron instances (node 0 and node 2, N=2) sharing a preloaded weight RAM,
// each with its own behavioural FP unit of fixed latency 3.

`timescale 1ns/1ps

module tb_forward_propagation_hidden_node;

    localparam int DW     = 32;
    localparam int AW     = 11;
    localparam int N      = 2;
    localparam int FP_LAT = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int lat_basic = 0;

    logic [DW-1:0] wram [0:15];

    // Instance A: node 0
    logic          in_valid_a;
    logic [DW-1:0] in_data_a;
    logic          ready_a;
    logic [AW-1:0] waddr_a;
    logic          wen_a;
    logic [DW-1:0] wdata_a = '0;
    logic          op_a;
    logic [DW-1:0] fa_a;
    logic [DW-1:0] fb_a;
    logic          fv_a;
    logic [DW-1:0] fres_a;
    logic          fpv_a;
    logic [DW-1:0] odata_a;
    logic          ovalid_a;
    logic [DW-1:0] model_res_a  = '0;
    logic [DW-1:0] model_pend_a = '0;
    logic          model_v_a    = 1'b0;
    int            model_cnt_a  = 0;
    logic          stray_a;

    // Instance B: node 2
    logic          in_valid_b;
    logic [DW-1:0] in_data_b;
    logic          ready_b;
    logic [AW-1:0] waddr_b;
    logic          wen_b;
    logic [DW-1:0] wdata_b = '0;
    logic          op_b;
    logic [DW-1:0] fa_b;
    logic [DW-1:0] fb_b;
    logic          fv_b;
    logic [DW-1:0] odata_b;
    logic          ovalid_b;
    logic [DW-1:0] model_res_b  = '0;
    logic [DW-1:0] model_pend_b = '0;
    logic          model_v_b    = 1'b0;
    int            model_cnt_b  = 0;

    assign fres_a = stray_a ? 32'hDEADBEEF : model_res_a;
    assign fpv_a  = model_v_a | stray_a;

    forward_propagation_hidden_node #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ADDRESS_NODE(0), .NUMBER_OF_BACK_NODE(N)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_valid(in_valid_a), .i_data(in_data_a), .o_ready(ready_a),
        .o_weight_addr(waddr_a), .o_weight_en(wen_a), .i_weight(wdata_a),
        .o_fp_op(op_a), .o_fp_a(fa_a), .o_fp_b(fb_a), .o_fp_valid(fv_a),
        .i_fp_result(fres_a), .i_fp_valid(fpv_a),
        .o_data(odata_a), .o_valid(ovalid_a)
    );

    forward_propagation_hidden_node #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ADDRESS_NODE(2), .NUMBER_OF_BACK_NODE(N)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_valid(in_valid_b), .i_data(in_data_b), .o_ready(ready_b),
        .o_weight_addr(waddr_b), .o_weight_en(wen_b), .i_weight(wdata_b),
        .o_fp_op(op_b), .o_fp_a(fa_b), .o_fp_b(fb_b), .o_fp_valid(fv_b),
        .i_fp_result(model_res_b), .i_fp_valid(model_v_b),
        .o_data(odata_b), .o_valid(ovalid_b)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] de;
        if (f[30:23] == 8'd0) return 0.0;
        de = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], de, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] de;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        de = d[62:52] - 11'd896;
        return {d[63], de[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_unit(input logic op, input logic [31:0] a, input logic [31:0] b);
        real ra;
        real rb;
        ra = f2r(a);
        rb = f2r(b);
        return op ? r2f(ra + rb) : r2f(ra * rb);
    endfunction

    // Weight RAM read ports: one-cycle read latency.
    always @(posedge clk) begin
        if (wen_a) wdata_a <= wram[waddr_a[3:0]];
        if (wen_b) wdata_b <= wram[waddr_b[3:0]];
    end

    // FP unit for instance A: result sampled by the DUT FP_LAT edges after the request edge.
    always @(posedge clk) begin
        model_v_a <= 1'b0;
        if (model_cnt_a != 0) begin
            model_cnt_a <= model_cnt_a - 1;
            if (model_cnt_a == 1) begin
                model_v_a   <= 1'b1;
                model_res_a <= model_pend_a;
            end
        end
        if (fv_a) begin
            model_pend_a <= fp_unit(op_a, fa_a, fb_a);
            model_cnt_a  <= FP_LAT - 1;
        end
    end

    // FP unit for instance B, identical timing.
    always @(posedge clk) begin
        model_v_b <= 1'b0;
        if (model_cnt_b != 0) begin
            model_cnt_b <= model_cnt_b - 1;
            if (model_cnt_b == 1) begin
                model_v_b   <= 1'b1;
                model_res_b <= model_pend_b;
            end
        end
        if (fv_b) begin
            model_pend_b <= fp_unit(op_b, fa_b, fb_b);
            model_cnt_b  <= FP_LAT - 1;
        end
    end

    // Drives two beats into instance A starting at the current negedge, then waits for o_valid.
    task automatic run_a(input logic [31:0] x0, input logic [31:0] x1, input bit keep_valid,
                         input bit stray, output bit got, output logic [31:0] data,
                         output int lat, output int ready_hi);
        got      = 1'b0;
        data     = '0;
        lat      = 0;
        ready_hi = 0;
        in_valid_a = 1'b1;
        in_data_a  = x0;
        @(negedge clk);
        in_data_a  = x1;
        @(negedge clk);
        in_valid_a = keep_valid;
        in_data_a  = 32'h7F7F0000;
        for (int i = 1; i <= 300 && !got; i++) begin
            if (ovalid_a) begin
                got  = 1'b1;
                data = odata_a;
                lat  = i;
            end else begin
                if (ready_a) ready_hi++;
                stray_a   = stray && wen_a;
                in_data_a = in_data_a + 32'd1;
                @(negedge clk);
            end
        end
        in_valid_a = 1'b0;
        stray_a    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ready_a !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready_a); else passed++;
        checks++; if (ovalid_a !== 1'b0) $display("[TB] FAIL reset_o_valid: got %b expected 0", ovalid_a); else passed++;
        checks++; if (odata_a !== 32'h0) $display("[TB] FAIL reset_o_data: got %h expected 00000000", odata_a); else passed++;
        checks++; if (wen_a !== 1'b0) $display("[TB] FAIL reset_weight_en: got %b expected 0", wen_a); else passed++;
        checks++; if (fv_a !== 1'b0) $display("[TB] FAIL reset_fp_valid: got %b expected 0", fv_a); else passed++;
        checks++; if (waddr_a !== 11'd0) $display("[TB] FAIL reset_weight_addr: got %0d expected 0", waddr_a); else passed++;
        checks++; if (fa_a !== 32'h0 || fb_a !== 32'h0) $display("[TB] FAIL reset_operands: got %h/%h expected 0/0", fa_a, fb_a); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ready_b !== 1'b1) $display("[TB] FAIL reset_ready_b: got %b expected 1", ready_b); else passed++;
    endtask

    task automatic test_basic();
        bit got;
        logic [31:0] d;
        int lat, rh, extra;
        @(negedge clk);
        run_a(32'h3F800000, 32'h40000000, 1'b0, 1'b0, got, d, lat, rh);
        lat_basic = lat;
        checks++; if (!got) $display("[TB] FAIL basic_timeout: got no o_valid expected one pulse"); else passed++;
        checks++; if (d !== 32'h40000000) $display("[TB] FAIL basic_data: got %h expected 40000000", d); else passed++;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (ovalid_a) extra++;
        end
        checks++; if (extra != 0) $display("[TB] FAIL basic_single_pulse: got %0d extra pulses expected 0", extra); else passed++;
        checks++; if (ready_a !== 1'b1) $display("[TB] FAIL basic_ready_after: got %b expected 1", ready_a); else passed++;
    endtask

    task automatic test_relu();
        bit got;
        logic [31:0] d;
        int lat, rh;
        wram[2] = 32'hC0400000;
        @(negedge clk);
        run_a(32'h3F800000, 32'h40000000, 1'b0, 1'b0, got, d, lat, rh);
        checks++; if (!got) $display("[TB] FAIL relu_timeout: got no o_valid expected one pulse"); else passed++;
        checks++; if (d !== 32'h00000000) $display("[TB] FAIL relu_data: got %h expected 00000000", d); else passed++;
        checks++; if (lat != lat_basic) $display("[TB] FAIL relu_latency: got %0d expected %0d", lat, lat_basic); else passed++;
        wram[2] = 32'h3F800000;
    endtask

    task automatic test_node2();
        bit got;
        logic [31:0] d;
        logic [AW-1:0] addr_q[$];
        logic op_q[$];
        logic [31:0] a_q[$];
        logic [31:0] b_q[$];
        logic [AW-1:0] exp_addr [3];
        logic exp_op [4];
        logic [31:0] exp_a [4];
        logic [31:0] exp_b [4];
        logic [AW-1:0] act_addr;
        logic act_op;
        logic [31:0] act_a;
        logic [31:0] act_b;
        exp_addr = '{11'd6, 11'd7, 11'd8};
        exp_op   = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_a    = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40600000};
        exp_b    = '{32'h40000000, 32'h3F000000, 32'h3FC00000, 32'hBF800000};
        got = 1'b0;
        d   = '0;
        @(negedge clk);
        in_valid_b = 1'b1;
        in_data_b  = 32'h3F800000;
        @(negedge clk);
        in_data_b  = 32'h40400000;
        @(negedge clk);
        in_valid_b = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (wen_b) addr_q.push_back(waddr_b);
            if (fv_b) begin
                op_q.push_back(op_b);
                a_q.push_back(fa_b);
                b_q.push_back(fb_b);
            end
            if (ovalid_b) begin
                got = 1'b1;
                d   = odata_b;
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (!got) $display("[TB] FAIL node2_timeout: got no o_valid expected one pulse"); else passed++;
        checks++; if (d !== 32'h40200000) $display("[TB] FAIL node2_data: got %h expected 40200000", d); else passed++;
        checks++; if (addr_q.size() != 3) $display("[TB] FAIL node2_fetch_count: got %0d expected 3", addr_q.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            act_addr = (i < addr_q.size()) ? addr_q[i] : 'x;
            checks++; if (act_addr !== exp_addr[i]) $display("[TB] FAIL node2_addr[%0d]: got %0d expected %0d", i, act_addr, exp_addr[i]); else passed++;
        end
        checks++; if (op_q.size() != 4) $display("[TB] FAIL node2_fp_requests: got %0d expected 4", op_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            act_op = (i < op_q.size()) ? op_q[i] : 1'bx;
            act_a  = (i < a_q.size()) ? a_q[i] : 'x;
            act_b  = (i < b_q.size()) ? b_q[i] : 'x;
            checks++; if (act_op !== exp_op[i]) $display("[TB] FAIL node2_op[%0d]: got %b expected %b", i, act_op, exp_op[i]); else passed++;
            checks++; if (act_a !== exp_a[i] || act_b !== exp_b[i])
                $display("[TB] FAIL node2_operands[%0d]: got %h/%h expected %h/%h", i, act_a, act_b, exp_a[i], exp_b[i]); else passed++;
        end
    endtask

    task automatic test_continuous();
        bit got;
        logic [31:0] d;
        int lat, rh;
        @(negedge clk);
        run_a(32'h3F800000, 32'h40000000, 1'b1, 1'b0, got, d, lat, rh);
        checks++; if (!got) $display("[TB] FAIL cont_timeout: got no o_valid expected one pulse"); else passed++;
        checks++; if (d !== 32'h40000000) $display("[TB] FAIL cont_data: got %h expected 40000000", d); else passed++;
        checks++; if (rh != 0) $display("[TB] FAIL cont_ready_busy: got %0d ready cycles expected 0", rh); else passed++;
        checks++; if (lat != lat_basic) $display("[TB] FAIL cont_latency: got %0d expected %0d", lat, lat_basic); else passed++;
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [31:0] d;
        int lat, rh;
        @(negedge clk);
        run_a(32'h3F800000, 32'h40000000, 1'b0, 1'b0, got, d, lat, rh);
        checks++; if (ready_a !== 1'b1) $display("[TB] FAIL b2b_ready_on_valid: got %b expected 1", ready_a); else passed++;
        run_a(32'h40000000, 32'h40800000, 1'b0, 1'b0, got, d, lat, rh);
        checks++; if (!got) $display("[TB] FAIL b2b_timeout: got no o_valid expected one pulse"); else passed++;
        checks++; if (d !== 32'h40400000) $display("[TB] FAIL b2b_data: got %h expected 40400000", d); else passed++;
    endtask

    task automatic test_reset_abort();
        bit got;
        bit seen;
        logic [31:0] d;
        int lat, rh, extra;
        seen = 1'b0;
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 32'h3F800000;
        @(negedge clk);
        in_data_a  = 32'h40000000;
        @(negedge clk);
        in_valid_a = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (fv_a) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen) $display("[TB] FAIL abort_mul_request: got no request expected one"); else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (ovalid_a) extra++;
        end
        checks++; if (extra != 0) $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", extra); else passed++;
        checks++; if (ready_a !== 1'b1) $display("[TB] FAIL abort_ready: got %b expected 1", ready_a); else passed++;
        run_a(32'h40000000, 32'h40800000, 1'b0, 1'b0, got, d, lat, rh);
        checks++; if (!got) $display("[TB] FAIL abort_rerun_timeout: got no o_valid expected one pulse"); else passed++;
        checks++; if (d !== 32'h40400000) $display("[TB] FAIL abort_rerun_data: got %h expected 40400000", d); else passed++;
    endtask

    task automatic test_stray();
        bit got;
        logic [31:0] d;
        int lat, rh;
        @(negedge clk);
        run_a(32'h3F800000, 32'h40000000, 1'b0, 1'b1, got, d, lat, rh);
        checks++; if (!got) $display("[TB] FAIL stray_timeout: got no o_valid expected one pulse"); else passed++;
        checks++; if (d !== 32'h40000000) $display("[TB] FAIL stray_data: got %h expected 40000000", d); else passed++;
    endtask

    initial begin
        in_valid_a = 1'b0;
        in_data_a  = '0;
        in_valid_b = 1'b0;
        in_data_b  = '0;
        stray_a    = 1'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < 16; i++) wram[i] = '0;
        wram[0] = 32'h3F000000;
        wram[1] = 32'h3E800000;
        wram[2] = 32'h3F800000;
        wram[6] = 32'h40000000;
        wram[7] = 32'h3F000000;
        wram[8] = 32'hBF800000;

        test_reset();
        test_basic();
        test_relu();
        test_node2();
        test_continuous();
        test_back_to_back();
        test_reset_abort();
        test_stray();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
